// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded integer register file.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW   = 5;
  localparam int DEF_TW   = 4;

  localparam logic [DEF_XLEN-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/rf_bypass_mux.sv
// Priority match of one read address against all writeback ports for same-cycle bypass.
module rf_bypass_mux
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW,
  parameter int NW   = 2,
  parameter int TW   = DEF_TW
) (
  input  logic             active,
  input  logic [AW-1:0]    rd_addr,
  input  logic [TW-1:0]    cur_tag,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic [NW*TW-1:0] wr_tag,
  output logic             hit,
  output logic [XLEN-1:0]  data,
  output logic             tag_match
);

  // Ascending scan so the highest-index matching port supplies the data.
  always_comb begin
    hit       = 1'b0;
    data      = '0;
    tag_match = 1'b0;
    for (int w = 0; w < NW; w++) begin
      if (active && wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr)) begin
        hit  = 1'b1;
        data = wr_data[w*XLEN +: XLEN];
        if (wr_tag[w*TW +: TW] == cur_tag)
          tag_match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register scoreboard (busy bit + producer tag).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int NR   = 2,
  parameter int NW   = 2,
  parameter int TW   = DEF_TW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [NR-1:0]      rd_en,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  output logic [NR*TW-1:0]   rd_tag,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic [NW*TW-1:0]   wr_tag,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  input  logic [TW-1:0]      rsv_tag,
  input  logic               flush
);

  localparam logic [XLEN-1:0] ZERO = XLEN'(ZERO_WORD);

  logic [XLEN-1:0] regs [NREG];
  logic [TW-1:0]   tags [NREG];
  logic [NREG-1:0] busy;

  // Later assignments override earlier ones: higher write port wins, flush beats clears,
  // and a reserve beats a same-cycle clear of its register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= ZERO;
        tags[r] <= '0;
      end
      busy <= '0;
    end else if (rdy) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
        if (wr_en[w] && busy[wr_addr[w*AW +: AW]] &&
            (tags[wr_addr[w*AW +: AW]] == wr_tag[w*TW +: TW]))
          busy[wr_addr[w*AW +: AW]] <= 1'b0;
      end
      if (flush) begin
        busy <= '0;
      end else if (rsv_en && (rsv_addr != '0)) begin
        busy[rsv_addr] <= 1'b1;
        tags[rsv_addr] <= rsv_tag;
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_read
    logic [AW-1:0]   addr;
    logic            valid;
    logic            hit;
    logic            tag_match;
    logic [XLEN-1:0] byp_data;

    assign addr  = rd_addr[i*AW +: AW];
    assign valid = !rst && rd_en[i] && (addr != '0);

    rf_bypass_mux #(
      .XLEN(XLEN),
      .AW  (AW),
      .NW  (NW),
      .TW  (TW)
    ) u_bypass (
      .active   (rdy),
      .rd_addr  (addr),
      .cur_tag  (tags[addr]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_tag   (wr_tag),
      .hit      (hit),
      .data     (byp_data),
      .tag_match(tag_match)
    );

    // A bypassing commit with a matching tag will clear busy, so report it as already clear.
    assign rd_data[i*XLEN +: XLEN] = !valid ? ZERO : (hit ? byp_data : regs[addr]);
    assign rd_busy[i]              = valid && busy[addr] && !(hit && tag_match);
    assign rd_tag[i*TW +: TW]      = valid ? tags[addr] : '0;
  end

endmodule
